stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Button front end and mode/run controller for the stopwatch datapath.
// Three raw buttons are synchronized, debounced and edge-detected. The
// resulting press events drive a small IDLE/RUN/PAUSE state machine that
// emits single-cycle command pulses to the datapath. Holding lap long
// enough issues a reset.
//
// Ports:
//   clk           system clock (1 kHz, shared with the datapath)
//   rst           asynchronous active-high reset
//   btn_mode      raw mode button (async, bouncy)
//   btn_ss        raw start/stop button (async, bouncy)
//   btn_lap       raw lap/reset button (async, bouncy)
//   sw_mode       1 = stopwatch mode active
//   start_stop_p  one-cycle start/stop command
//   lap_p         one-cycle lap command
//   reset_p       one-cycle reset command
//   state         00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int LONG_CYC     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic       sw_mode,
    output logic       start_stop_p,
    output logic       lap_p,
    output logic       reset_p,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        BAD   = 2'b11
    } state_t;

    // Button index within the packed vectors below
    localparam int BTN_MODE = 0;
    localparam int BTN_SS   = 1;
    localparam int BTN_LAP  = 2;

    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LCW = $clog2(LONG_CYC + 1);
    localparam logic [DCW-1:0] DB_MAX    = DCW'(DEBOUNCE_CYC - 1);
    localparam logic [LCW-1:0] LONG_MAX  = LCW'(LONG_CYC - 1);
    localparam logic [LCW-1:0] LONG_SAT  = LCW'(LONG_CYC);

    logic [2:0]     w_raw;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_db;
    logic [2:0]     r_dbPrev;
    logic [DCW-1:0] r_dbCnt [3];
    logic [LCW-1:0] r_longCnt;
    logic [2:0]     w_press;
    logic           w_longFire;

    state_t r_state;
    logic   r_swMode;
    logic   r_ssP;
    logic   r_lapP;
    logic   r_rstP;

    assign w_raw = {btn_lap, btn_ss, btn_mode};

    // Two-flop synchronizer on every raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a new level is accepted only after it has differed from the
    // debounced level for DEBOUNCE_CYC consecutive cycles; any return to the
    // old level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db     <= '0;
            r_dbPrev <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_dbPrev <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_MAX) begin
                    r_db[i]    <= r_sync2[i];
                    r_dbCnt[i] <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events are rising edges of the debounced level only
    assign w_press = r_db & ~r_dbPrev;

    // Long-press timer: counts while lap is held in stopwatch mode and parks
    // one past the firing value, so a single hold fires exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_longCnt <= '0;
        end else if (!r_db[BTN_LAP] || !r_swMode) begin
            r_longCnt <= '0;
        end else if (r_longCnt != LONG_SAT) begin
            r_longCnt <= r_longCnt + 1'b1;
        end
    end

    assign w_longFire = r_db[BTN_LAP] && r_swMode && (r_longCnt == LONG_MAX);

    // Controller: mode press beats everything; otherwise long-press reset >
    // start/stop > lap, with losing events simply dropped. Pulses default low
    // each cycle so none can stretch over two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_swMode <= 1'b0;
            r_ssP    <= 1'b0;
            r_lapP   <= 1'b0;
            r_rstP   <= 1'b0;
        end else begin
            r_ssP  <= 1'b0;
            r_lapP <= 1'b0;
            r_rstP <= 1'b0;
            if (w_press[BTN_MODE]) begin
                r_swMode <= ~r_swMode;
                if (r_swMode) begin
                    r_state <= IDLE;
                end
            end else if (!r_swMode) begin
                r_state <= IDLE;
            end else if (r_state == BAD) begin
                r_state <= IDLE;
            end else if (w_longFire) begin
                r_rstP  <= 1'b1;
                r_state <= IDLE;
            end else if (w_press[BTN_SS]) begin
                r_ssP <= 1'b1;
                case (r_state)
                    RUN:     r_state <= PAUSE;
                    default: r_state <= RUN;
                endcase
            end else if (w_press[BTN_LAP]) begin
                case (r_state)
                    RUN: begin
                        r_lapP <= 1'b1;
                    end
                    PAUSE: begin
                        r_rstP  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign sw_mode      = r_swMode;
    assign start_stop_p = r_ssP;
    assign lap_p        = r_lapP;
    assign reset_p      = r_rstP;
    assign state        = r_state;

endmodule
